// File: rtl/vscale_tohost_monitor.sv
// tohost/HTIF result monitor: snoops dmem stores to tohost, latches a sticky pass/fail/timeout verdict.
// Optional PC-window cycle counter enabled by defining VSCALE_TOHOST_PERF_EN.
module vscale_tohost_monitor #(
    parameter logic [31:0] TOHOST_ADDR   = 32'h00001000,
    parameter int unsigned XPR_LEN       = 32,
    parameter int unsigned CYCLE_W       = 64,
    parameter int unsigned MAX_CYCLES    = 0,
    parameter logic [31:0] PERF_START_PC = 32'h00001a60,
    parameter logic [31:0] PERF_STOP_PC  = 32'h00001a70
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               dmem_write,
    input  logic [31:0]        dmem_addr,
    input  logic [XPR_LEN-1:0] dmem_wdata,
    input  logic [31:0]        pc_dx,
    output logic               done,
    output logic               passed,
    output logic               failed,
    output logic               timeout,
    output logic [XPR_LEN-2:0] status_code,
    output logic [CYCLE_W-1:0] cycle_count,
    output logic [31:0]        perf_cycles,
    output logic               perf_valid
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_PASS    = 3'd2,
        S_FAIL    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_e;

    state_e             state_q;
    logic               resp_valid_q;
    logic [XPR_LEN-1:0] resp_data_q;
    logic               done_q;
    logic               passed_q;
    logic               failed_q;
    logic               timeout_q;
    logic [XPR_LEN-2:0] status_q;
    logic [CYCLE_W-1:0] cycle_q;
    logic [CYCLE_W-1:0] cycle_d;
    logic               timeout_hit;

    // Saturating run-cycle increment; timeout is judged on the value the counter is about to hold
    assign cycle_d     = (cycle_q == '1) ? cycle_q : cycle_q + CYCLE_W'(1);
    assign timeout_hit = (MAX_CYCLES != 0) && (cycle_d >= CYCLE_W'(MAX_CYCLES));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            done_q       <= 1'b0;
            passed_q     <= 1'b0;
            failed_q     <= 1'b0;
            timeout_q    <= 1'b0;
            status_q     <= '0;
            cycle_q      <= '0;
        end else begin
            resp_valid_q <= dmem_write && (dmem_addr == TOHOST_ADDR);
            resp_data_q  <= dmem_wdata;
            case (state_q)
                S_IDLE: state_q <= S_RUN;
                S_RUN: begin
                    cycle_q <= cycle_d;
                    if (resp_valid_q && (resp_data_q == XPR_LEN'(1))) begin
                        state_q  <= S_PASS;
                        passed_q <= 1'b1;
                        done_q   <= 1'b1;
                    end else if (resp_valid_q && (resp_data_q > XPR_LEN'(1))) begin
                        state_q  <= S_FAIL;
                        failed_q <= 1'b1;
                        done_q   <= 1'b1;
                        status_q <= resp_data_q[XPR_LEN-1:1];
                    end else if (timeout_hit) begin
                        state_q   <= S_TIMEOUT;
                        timeout_q <= 1'b1;
                        done_q    <= 1'b1;
                    end
                end
                default: state_q <= state_q;
            endcase
        end
    end

    assign done        = done_q;
    assign passed      = passed_q;
    assign failed      = failed_q;
    assign timeout     = timeout_q;
    assign status_code = status_q;
    assign cycle_count = cycle_q;

`ifdef VSCALE_TOHOST_PERF_EN
    typedef enum logic [1:0] {
        P_IDLE  = 2'd0,
        P_COUNT = 2'd1,
        P_DONE  = 2'd2
    } perf_state_e;

    perf_state_e perf_state_q;
    logic [31:0] perf_q;
    logic        perf_valid_q;

    // Single-shot window: the stop edge itself is counted, later windows are ignored
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_state_q <= P_IDLE;
            perf_q       <= '0;
            perf_valid_q <= 1'b0;
        end else begin
            case (perf_state_q)
                P_IDLE: begin
                    if ((state_q == S_RUN) && (pc_dx == PERF_START_PC)) begin
                        perf_state_q <= P_COUNT;
                    end
                end
                P_COUNT: begin
                    if (perf_q != 32'hFFFF_FFFF) begin
                        perf_q <= perf_q + 32'd1;
                    end
                    if (pc_dx == PERF_STOP_PC) begin
                        perf_state_q <= P_DONE;
                        perf_valid_q <= 1'b1;
                    end
                end
                default: perf_state_q <= perf_state_q;
            endcase
        end
    end

    assign perf_cycles = perf_q;
    assign perf_valid  = perf_valid_q;
`else
    logic unused_pc_dx;

    assign unused_pc_dx = ^pc_dx;
    assign perf_cycles  = 32'd0;
    assign perf_valid   = 1'b0;
`endif

endmodule
